display_scan_ctrl: RTL and testbench

Scan scheduler for the two-digit 7-segment display. It generates digit select and segment drive from two 7-bit segment patterns, with a programmable slot period, a blanking dead-time at every digit switch (anti-ghosting), 16-level PWM brightness, and double-buffered digit updates. Digit updates use a load/ack handshake and take effect only on frame boundaries. It sits between the pattern producers (decoders, counters) and the display pins, and replaces free-running divided-clock muxing.

---
 rtl/display_scan_ctrl.sv | 115 +++++++++++
 tb/tb_display_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment scan scheduler: slot timing with blanking dead-time,
// 16-level PWM on-window, and frame-aligned double-buffered pattern updates.
module display_scan_ctrl #(
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] disp0_in,
    input  logic [6:0] disp1_in,
    input  logic       load,
    output logic       load_ack,
    input  logic [3:0] brightness,
    output logic [6:0] seg,
    output logic [1:0] anode,
    output logic       frame_start
);
    localparam int CW = $clog2(SLOT_CYCLES);

    typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} slot_state_t;

    slot_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          digit, digit_n;
    logic [3:0]    bright_q, bright_eff;
    logic [31:0]   on_len;
    logic [6:0]    shadow0, shadow1, active0, active1;
    logic          pending;
    logic          running, slot_end, boundary;

    always_comb begin
        running  = (state != IDLE);
        slot_end = running && (cnt == CW'(SLOT_CYCLES - 1));
        boundary = enable && slot_end && digit;
        // During c=0 the live input is the slot's brightness; afterwards the latched copy.
        bright_eff = (running && cnt == '0) ? brightness : bright_q;
        on_len = (32'(SLOT_CYCLES - BLANK_CYCLES) * (32'(bright_eff) + 32'd1)) / 32'd16;

        cnt_n   = '0;
        digit_n = 1'b0;
        state_n = IDLE;
        if (!enable) begin
            state_n = IDLE;
        end else if (!running) begin
            state_n = BLANK;
        end else begin
            if (slot_end) begin
                cnt_n   = '0;
                digit_n = ~digit;
            end else begin
                cnt_n   = cnt + CW'(1);
                digit_n = digit;
            end
            if (32'(cnt_n) < 32'(BLANK_CYCLES))
                state_n = BLANK;
            else if (32'(cnt_n) < 32'(BLANK_CYCLES) + on_len)
                state_n = ON;
            else
                state_n = OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit       <= 1'b0;
            bright_q    <= '0;
            shadow0     <= '0;
            shadow1     <= '0;
            active0     <= '0;
            active1     <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            seg         <= '0;
            anode       <= '0;
            frame_start <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            digit <= digit_n;
            if (running && cnt == '0)
                bright_q <= brightness;

            // anode and seg come from the same next state so they switch together.
            frame_start <= (state_n != IDLE) && (cnt_n == '0) && !digit_n;
            anode       <= (state_n == ON) ? (digit_n ? 2'b10 : 2'b01) : 2'b00;
            seg         <= (state_n == ON) ? (digit_n ? active1 : active0) : 7'd0;

            load_ack <= 1'b0;
            if (boundary) begin
                if (load) begin
                    active0  <= disp0_in;
                    active1  <= disp1_in;
                    load_ack <= 1'b1;
                end else if (pending) begin
                    active0  <= shadow0;
                    active1  <= shadow1;
                    load_ack <= 1'b1;
                end
                pending <= 1'b0;
            end else if (!running && !load && pending) begin
                active0  <= shadow0;
                active1  <= shadow1;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                shadow0 <= disp0_in;
                shadow1 <= disp1_in;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus a random run, all
// compared against a frame-position model of the display.
module tb_display_scan_ctrl;
    localparam int SLOT  = 32;
    localparam int BL    = 4;
    localparam int FRAME = 2 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n, enable, load;
    logic [6:0] d0, d1;
    logic [3:0] brightness;
    logic       load_ack, frame_start;
    logic [6:0] seg;
    logic [1:0] anode;

    int total = 0;
    int bad   = 0;

    // Reference model state: frame position t in 0..FRAME-1 while running.
    bit         m_run = 0;
    int         m_t = 0;
    int         m_bright = 0;
    logic [6:0] m_a0 = '0, m_a1 = '0, m_sh0 = '0, m_sh1 = '0;
    bit         m_pend = 0, m_ack = 0;
    logic [1:0] e_an = '0;
    logic [6:0] e_seg = '0;
    logic       e_fs = 1'b0, e_ack = 1'b0;

    display_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .disp0_in(d0), .disp1_in(d1), .load(load), .load_ack(load_ack),
        .brightness(brightness), .seg(seg), .anode(anode), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Advance one clock, update the model from the sampled inputs, settle.
    task automatic tick();
        bit bnd;
        int c, dg, on;
        @(posedge clk);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_pend = 0; m_ack = 0;
            m_sh0 = '0; m_sh1 = '0; m_a0 = '0; m_a1 = '0;
        end else begin
            bnd = enable && m_run && (m_t == FRAME - 1);
            m_ack = 0;
            if (bnd) begin
                if (load) begin m_a0 = d0; m_a1 = d1; m_ack = 1; end
                else if (m_pend) begin m_a0 = m_sh0; m_a1 = m_sh1; m_ack = 1; end
                m_pend = 0;
            end else if (!m_run && !load && m_pend) begin
                m_a0 = m_sh0; m_a1 = m_sh1; m_pend = 0; m_ack = 1;
            end else if (load) begin
                m_sh0 = d0; m_sh1 = d1; m_pend = 1;
            end
            if (m_run && (m_t % SLOT) == 0) m_bright = int'(brightness);
            if (!enable) begin m_run = 0; m_t = 0; end
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t = (m_t + 1) % FRAME;
        end
        c  = m_t % SLOT;
        dg = m_t / SLOT;
        on = ((SLOT - BL) * (m_bright + 1)) / 16;
        e_an = 2'b00; e_seg = '0;
        if (m_run && c >= BL && c < BL + on) begin
            e_an  = dg ? 2'b10 : 2'b01;
            e_seg = dg ? m_a1 : m_a0;
        end
        e_fs  = m_run && (m_t == 0);
        e_ack = m_ack;
        #1;
    endtask

    task automatic wait_t(input int t);
        int n = 0;
        while (!(m_run && m_t == t) && n < 4 * FRAME) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 1; tick(); tick();
        total++;
        if ({anode, seg, frame_start, load_ack} !== 11'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {anode, seg, frame_start, load_ack});
        end
        enable = 0; rst_n = 1; tick();
        total++;
        if ({anode, seg, frame_start, load_ack} !== 11'd0) begin
            bad++; $display("FAIL idle_outputs: got %h want 0", {anode, seg, frame_start, load_ack});
        end
    endtask

    task automatic test_scan();
        int on0 = 0, on1 = 0, fs1 = -1, fs2 = -1;
        d0 = 7'h3F; d1 = 7'h06; load = 1; tick(); load = 0; tick();
        total++;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL idle_load_ack: got %b want 1", load_ack); end
        enable = 1; brightness = 4'd15;
        for (int i = 0; i < 130; i++) begin
            tick();
            total++;
            if ({anode, seg, frame_start, load_ack} !== {e_an, e_seg, e_fs, e_ack}) begin
                bad++; $display("FAIL scan_cycle t=%0d: got %h want %h", m_t,
                    {anode, seg, frame_start, load_ack}, {e_an, e_seg, e_fs, e_ack});
            end
            if (i < FRAME && anode == 2'b01 && seg == 7'h3F) on0++;
            if (i < FRAME && anode == 2'b10 && seg == 7'h06) on1++;
            if (frame_start) begin if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i; end
        end
        total++; if (on0 != 28) begin bad++; $display("FAIL digit0_on_len: got %0d want 28", on0); end
        total++; if (on1 != 28) begin bad++; $display("FAIL digit1_on_len: got %0d want 28", on1); end
        total++; if (fs2 - fs1 != FRAME) begin bad++; $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FRAME); end
    endtask

    task automatic test_brightness();
        int on_a, on_b;
        int want_tot[2] = '{28, 2};
        int lvl[2] = '{7, 0};
        for (int k = 0; k < 2; k++) begin
            brightness = 4'(lvl[k]);
            wait_t(FRAME - 1);
            on_a = 0;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                total++;
                if ({anode, seg} !== {e_an, e_seg}) begin
                    bad++; $display("FAIL bright_cycle t=%0d: got %h want %h", m_t, {anode, seg}, {e_an, e_seg});
                end
                if (anode != 2'b00) on_a++;
            end
            total++;
            if (on_a != want_tot[k]) begin bad++; $display("FAIL bright_%0d_on: got %0d want %0d", lvl[k], on_a, want_tot[k]); end
        end
        on_a = 0; on_b = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i == 10) brightness = 4'd3;
            if (anode != 2'b00) begin if (i < SLOT) on_a++; else on_b++; end
        end
        total++; if (on_a != 1) begin bad++; $display("FAIL bright_midslot_hold: got %0d want 1", on_a); end
        total++; if (on_b != 7) begin bad++; $display("FAIL bright_next_slot: got %0d want 7", on_b); end
    endtask

    task automatic test_load();
        int n = 0;
        brightness = 4'd15;
        wait_t(5);
        d0 = 7'h5B; d1 = 7'h4F; load = 1; tick(); load = 0;
        while (m_t != 0 && n < FRAME) begin
            total++;
            if ({anode, seg, load_ack} !== {e_an, e_seg, e_ack}) begin
                bad++; $display("FAIL load_old_frame t=%0d: got %h want %h", m_t, {anode, seg, load_ack}, {e_an, e_seg, e_ack});
            end
            if (m_t == 40 && seg !== 7'h06) begin bad++; $display("FAIL load_old_digit1: got %h want 06", seg); end
            tick(); n++;
        end
        total++;
        if ({frame_start, load_ack} !== 2'b11) begin bad++; $display("FAIL load_ack_at_frame: got %b want 11", {frame_start, load_ack}); end
        for (int i = 0; i < BL; i++) tick();
        total++;
        if ({anode, seg} !== {2'b01, 7'h5B}) begin bad++; $display("FAIL load_new_digit0: got %h want %h", {anode, seg}, {2'b01, 7'h5B}); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        wait_t(10); d0 = 7'h11; d1 = 7'h22; load = 1; tick(); load = 0;
        wait_t(40); d0 = 7'h33; d1 = 7'h44; load = 1; tick(); load = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            total++;
            if ({anode, seg, frame_start, load_ack} !== {e_an, e_seg, e_fs, e_ack}) begin
                bad++; $display("FAIL b2b_cycle t=%0d: got %h want %h", m_t,
                    {anode, seg, frame_start, load_ack}, {e_an, e_seg, e_fs, e_ack});
            end
            if (load_ack) acks++;
            if (m_t == BL && seg !== 7'h33) begin bad++; $display("FAIL b2b_last_wins: got %h want 33", seg); end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL b2b_ack_count: got %0d want 1", acks); end
        wait_t(FRAME - 1);
        d0 = 7'h55; d1 = 7'h66; load = 1; tick(); load = 0;
        total++;
        if ({frame_start, load_ack} !== 2'b11) begin bad++; $display("FAIL boundary_load_ack: got %b want 11", {frame_start, load_ack}); end
        for (int i = 0; i < BL; i++) tick();
        total++;
        if (seg !== 7'h55) begin bad++; $display("FAIL boundary_load_seg: got %h want 55", seg); end
    endtask

    task automatic test_enable();
        wait_t(10);
        enable = 0; tick();
        total++;
        if ({anode, seg, frame_start} !== 10'd0) begin bad++; $display("FAIL disable_dark: got %h want 0", {anode, seg, frame_start}); end
        d0 = 7'h77; d1 = 7'h08; load = 1; tick(); load = 0; tick();
        total++;
        if ({load_ack, anode} !== 3'b100) begin bad++; $display("FAIL disabled_ack: got %b want 100", {load_ack, anode}); end
        enable = 1; tick();
        total++;
        if ({frame_start, anode} !== 3'b100) begin bad++; $display("FAIL reenable_frame: got %b want 100", {frame_start, anode}); end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++;
            if ({anode, seg, frame_start, load_ack} !== {e_an, e_seg, e_fs, e_ack}) begin
                bad++; $display("FAIL reenable_cycle t=%0d: got %h want %h", m_t,
                    {anode, seg, frame_start, load_ack}, {e_an, e_seg, e_fs, e_ack});
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0, lit = 0;
        wait_t(20);
        d0 = 7'h7F; d1 = 7'h7E; load = 1; tick(); load = 0;
        rst_n = 0; tick();
        total++;
        if ({anode, seg, frame_start, load_ack} !== 11'd0) begin
            bad++; $display("FAIL midreset_outputs: got %h want 0", {anode, seg, frame_start, load_ack});
        end
        rst_n = 1; tick();
        total++;
        if ({frame_start, anode} !== 3'b100) begin bad++; $display("FAIL midreset_restart: got %b want 100", {frame_start, anode}); end
        for (int i = 0; i < 70; i++) begin
            tick();
            if (load_ack) acks++;
            if (seg != 7'd0) lit++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL midreset_no_ack: got %0d want 0", acks); end
        total++; if (lit != 0) begin bad++; $display("FAIL midreset_active_zero: got %0d want 0", lit); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 99) < 97);
            load   = ($urandom_range(0, 47) == 0);
            d0 = 7'($urandom); d1 = 7'($urandom);
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
            tick();
            total++;
            if ({anode, seg, frame_start, load_ack} !== {e_an, e_seg, e_fs, e_ack}) begin
                bad++; $display("FAIL rand_cycle %0d: got %h want %h", i,
                    {anode, seg, frame_start, load_ack}, {e_an, e_seg, e_fs, e_ack});
            end
            total++;
            if (anode === 2'b11) begin bad++; $display("FAIL rand_anode_11: got %b want not 11", anode); end
            total++;
            if (anode === 2'b00 && seg !== 7'd0) begin bad++; $display("FAIL rand_dark_seg: got %h want 0", seg); end
        end
        load = 0;
    endtask

    initial begin
        rst_n = 0; enable = 0; load = 0; d0 = '0; d1 = '0; brightness = '0;
        test_reset();
        test_scan();
        test_brightness();
        test_load();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
